// File: rtl/bd_shift_reg_univ.sv
// Universal bidirectional shift register: shift/rotate/arithmetic/load/clear single steps, plus
// an auto-sequenced "shift by N" run with busy/done handshake.
module bd_shift_reg_univ #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             en,
  input  logic             dr,
  input  logic             dl,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             so_r,
  output logic             so_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [2:0]       mode_q, mode_d;
  logic [AMT_W-1:0] rem_q, rem_d;

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] cur,
                                                input logic             sin_r,
                                                input logic             sin_l,
                                                input logic [WIDTH-1:0] load);
    logic [WIDTH-1:0] res;
    case (op)
      3'b001:  res = {sin_r, cur[WIDTH-1:1]};
      3'b010:  res = {cur[WIDTH-2:0], sin_l};
      3'b011:  res = {cur[0], cur[WIDTH-1:1]};
      3'b100:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b101:  res = load;
      3'b110:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      3'b111:  res = '0;
      default: res = cur;
    endcase
    return res;
  endfunction

  function automatic logic is_auto(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b010) || (op == 3'b011) ||
           (op == 3'b100) || (op == 3'b110);
  endfunction

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    case (state_q)
      StRun: begin
        // Serial inputs stay live during a run; only the operation is latched.
        q_d   = apply_op(mode_q, q_q, dr, dl, pdata);
        rem_d = rem_q - AMT_W'(1);
        if (rem_q == AMT_W'(1)) begin
          state_d = StDone;
        end
      end
      default: begin
        state_d = StIdle;
        if (start && is_auto(mode)) begin
          mode_d = mode;
          if (amt != '0) begin
            q_d     = apply_op(mode, q_q, dr, dl, pdata);
            rem_d   = amt - AMT_W'(1);
            state_d = (amt == AMT_W'(1)) ? StDone : StRun;
          end else begin
            rem_d   = '0;
            state_d = StDone;
          end
        end else if (en) begin
          q_d = apply_op(mode, q_q, dr, dl, pdata);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      q_q     <= '0;
      mode_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
    end
  end

  assign q    = q_q;
  assign qbar = ~q_q;
  assign so_r = q_q[0];
  assign so_l = q_q[WIDTH-1];
  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);

endmodule

// File: doc/bd_shift_reg_univ.md
Name: bd_shift_reg_univ

Overview:
- Parametrised universal bidirectional shift register, the successor to the fixed 4-bit left/right shift register.
- Adds:
  - generic WIDTH;
  - rotate, arithmetic-shift, parallel-load and clear modes;
  - an auto-sequenced "shift by N" operation with busy/done handshake.
- Sits in the datapath as a serial/parallel converter and barrel-shift substitute for control FSMs.

Parameters:
- WIDTH, 8, register width in bits; must be >= 2.
- AMT_W, 4, width of the shift-amount input; max auto count is 2^AMT_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- mode  input  3  operation select (see Behaviour)
- en  input  1  single-step enable; applies mode once on the sampled edge
- dr  input  1  serial data in for right shift; enters at q[WIDTH-1]
- dl  input  1  serial data in for left shift; enters at q[0]
- pdata  input  WIDTH  parallel load data
- start  input  1  request auto-sequenced shift/rotate of amt steps
- amt  input  AMT_W  step count for auto operation
- q  output  WIDTH  register contents
- qbar  output  WIDTH  bitwise complement of q
- so_r  output  1  serial out on right shift, = q[0]
- so_l  output  1  serial out on left shift, = q[WIDTH-1]
- busy  output  1  auto operation in progress
- done  output  1  one-cycle pulse when auto operation completes

Behaviour:
- Reset: asynchronous, active-high, via clk and rst as named above. While rst is high:
  - q=0 and qbar=all ones, immediately, with no clock edge needed.
  - busy=0, done=0, FSM in IDLE, step counter=0.
  - Reset mid-run aborts the run with no done pulse.
- Output derivation: qbar, so_r and so_l are combinational from the q register; no extra latency.
- Mode encoding, one application per edge. "Right" moves bits toward index 0; "left" moves bits toward the MSB.
  - 000: hold.
  - 001: shift right. q[i]<=q[i+1]; q[WIDTH-1]<=dr.
  - 010: shift left. q[i]<=q[i-1]; q[0]<=dl.
  - 011: rotate right. q[WIDTH-1]<=q[0].
  - 100: rotate left. q[0]<=q[WIDTH-1].
  - 101: parallel load. q<=pdata.
  - 110: arithmetic shift right. MSB is retained.
  - 111: clear. q<=0.
- Auto-capable modes: 001, 010, 011, 100, 110. Start with any other mode is ignored: no busy, no done, and en is evaluated normally.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE:
  - If start=1 with an auto-capable mode:
    - Latch the mode.
    - If amt=k>=1: apply the op on this same edge and load remaining=k-1. Next state is DONE if k=1, else RUN.
    - If amt=0: q unchanged; next state DONE.
  - Else if en=1: apply mode once; next state IDLE.
  - start has priority over en.
- RUN:
  - Each edge applies the latched op and decrements remaining.
  - When remaining reaches 0 on this edge, next state is DONE.
  - mode, en and start are ignored in RUN.
  - dr and dl are sampled live every edge, not latched.
- Timing of an auto operation:
  - Exactly k ops occur, at edges E0..E0+k-1, where E0 is the start edge.
  - busy=1 only while in RUN. For k=1 and k=0, busy never asserts.
  - done=1 for exactly the one cycle spent in DONE.
- Back-to-back: a start in the DONE cycle is accepted exactly as in IDLE; done still pulses for that one cycle.
- Counter width is AMT_W. There is no wrap, because the count is loaded once and only decremented down to 0.
- Serial-in note: in modes 011, 100 and 110, dr and dl are don't-care.

Test Plan (WIDTH=8, AMT_W=4):
- Reset: assert rst between clock edges with q=5A → q=00 and qbar=FF immediately; busy=0, done=0; q holds 00 across edges while rst=1.
- Single-step ops, in sequence:
  - mode=101, pdata=A5, en=1 → q=A5.
  - mode=001, dr=1, en=1 → q=D2, so_r=0.
  - mode=010, dl=0, en=1 → q=A4.
  - en=0 with any mode → q unchanged.
- Auto rotate: q=81, start=1, mode=100, amt=3 → q=03, 06, 0C on edges E0, E0+1, E0+2; busy=1 for 2 cycles; done=1 for one cycle after E0+2; final q=0C.
- Arithmetic shift and clear:
  - q=80, mode=110, en=1 twice → C0, then E0.
  - mode=111, en=1 → 00.
- Edge cases:
  - start with amt=0 → done pulses the next cycle, busy stays 0, q unchanged.
  - start with mode=101 → ignored; en governs.
  - start/mode changes during RUN → ignored.
- Reset mid-run: start, mode=001, amt=8, dr=1 from q=00; assert rst after 3 edges → q=00 immediately, busy=0, no done pulse; the FSM accepts a new start after rst deasserts.
